// File: rtl/bpu_pkg.sv
// bpu_pkg: shared types, constants and helpers for the branch prediction unit.
//   BHT_IDX_W / BHT_DEPTH : table index width and depth
//   BHT_INIT_CTR          : counter value loaded by the init sweep (weakly-not-taken)
//   bht_ctr_t             : 2-bit saturating counter
//   bht_state_e           : controller state (sweep / run)
//   sat_update()          : saturating counter step toward the resolved outcome
package bpu_pkg;

    localparam int BHT_IDX_W = 10;
    localparam int BHT_DEPTH = 1 << BHT_IDX_W;

    typedef logic [1:0] bht_ctr_t;

    // The state enum already owns the name BHT_INIT, so the reset counter
    // value carries an explicit _CTR suffix.
    localparam bht_ctr_t BHT_INIT_CTR = 2'b01;

    typedef enum logic {
        BHT_INIT,
        BHT_RUN
    } bht_state_e;

    function automatic bht_ctr_t sat_update(input bht_ctr_t ctr, input logic taken);
        bht_ctr_t res;
        res = ctr;
        if (taken) begin
            if (ctr != 2'b11) res = ctr + 2'd1;
        end else begin
            if (ctr != 2'b00) res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/Const.svh
// Global width constants shared by the fetch/execute datapath blocks.
`ifndef CONST_SVH
`define CONST_SVH
`define DATA_WID 32
`endif

// File: rtl/bht_ram.sv
// bht_ram: depth x 2-bit counter storage.
//   clk                    : clock
//   we_i/waddr_i/wdata_i   : single synchronous write port
//   lk_addr_i/lk_data_o    : asynchronous read port for IF lookups
//   up_addr_i/up_data_o    : asynchronous read port for EX updates
// All write arbitration lives in the controller; this block is pure storage.
module bht_ram
    import bpu_pkg::*;
#(
    parameter int IDX_W = BHT_IDX_W
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [1:0]       wdata_i,
    input  logic [IDX_W-1:0] lk_addr_i,
    output logic [1:0]       lk_data_o,
    input  logic [IDX_W-1:0] up_addr_i,
    output logic [1:0]       up_data_o
);

    localparam int DEPTH = 1 << IDX_W;

    logic [1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign lk_data_o = mem_q[lk_addr_i];
    assign up_data_o = mem_q[up_addr_i];

endmodule

// File: rtl/bht_controller.sv
// bht_controller: owns the branch history table.
//   clk, rst            : clock, synchronous active-high reset
//   clear_req           : pulse; flushes stats/pending update and restarts the sweep
//   lookup_pc           : IF-stage PC, index = pc[IDX_W+1:2]
//   predict_taken       : counter MSB of the looked-up entry, forced 0 while busy
//   upd_valid/upd_pc/upd_taken/upd_mispredict : resolved-branch update from EX
//   busy                : init sweep in progress
//   branch_cnt, mispredict_cnt : saturating statistics
// An accepted update computes its new counter value in the same cycle (reading
// through the pending entry), parks it in a one-entry pending stage and writes
// it to the table on the following cycle.
`include "Const.svh"

module bht_controller
    import bpu_pkg::*;
#(
    parameter int         IDX_W    = BHT_IDX_W,
    parameter logic [1:0] INIT_CTR = BHT_INIT_CTR
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_req,
    input  logic [`DATA_WID-1:0] lookup_pc,
    output logic                 predict_taken,
    input  logic                 upd_valid,
    input  logic [`DATA_WID-1:0] upd_pc,
    input  logic                 upd_taken,
    input  logic                 upd_mispredict,
    output logic                 busy,
    output logic [31:0]          branch_cnt,
    output logic [31:0]          mispredict_cnt
);

    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    bht_state_e       state_q, state_d;
    logic [IDX_W-1:0] sweep_idx_q, sweep_idx_d;
    logic             pend_v_q, pend_v_d;
    logic [IDX_W-1:0] pend_idx_q, pend_idx_d;
    bht_ctr_t         pend_val_q, pend_val_d;

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic             ram_we;
    logic [IDX_W-1:0] ram_waddr;
    bht_ctr_t         ram_wdata;
    bht_ctr_t         ram_lk_data, ram_up_data;
    bht_ctr_t         upd_base, lk_ctr;
    logic             accept;

    // Only the index bits of either PC matter; the rest alias by design.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[`DATA_WID-1:IDX_W+2], lookup_pc[1:0],
                              upd_pc[`DATA_WID-1:IDX_W+2], upd_pc[1:0]};

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign up_idx = upd_pc[IDX_W+1:2];

    bht_ram #(.IDX_W(IDX_W)) u_ram (
        .clk       (clk),
        .we_i      (ram_we),
        .waddr_i   (ram_waddr),
        .wdata_i   (ram_wdata),
        .lk_addr_i (lk_idx),
        .lk_data_o (ram_lk_data),
        .up_addr_i (up_idx),
        .up_data_o (ram_up_data)
    );

    // The pending entry is not yet in the table; both readers must see it.
    assign upd_base = (pend_v_q && (pend_idx_q == up_idx)) ? pend_val_q : ram_up_data;
    assign lk_ctr   = (pend_v_q && (pend_idx_q == lk_idx)) ? pend_val_q : ram_lk_data;

    assign busy          = (state_q == BHT_INIT);
    assign predict_taken = (state_q == BHT_RUN) && lk_ctr[1];

    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        pend_v_d    = 1'b0;
        pend_idx_d  = pend_idx_q;
        pend_val_d  = pend_val_q;
        ram_we      = 1'b0;
        ram_waddr   = pend_idx_q;
        ram_wdata   = pend_val_q;
        accept      = 1'b0;

        case (state_q)
            BHT_INIT: begin
                ram_we      = 1'b1;
                ram_waddr   = sweep_idx_q;
                ram_wdata   = INIT_CTR;
                sweep_idx_d = sweep_idx_q + 1'b1;
                if (sweep_idx_q == LAST_IDX) begin
                    state_d = BHT_RUN;
                end
            end
            BHT_RUN: begin
                ram_we = pend_v_q;
                if (upd_valid) begin
                    accept     = 1'b1;
                    pend_v_d   = 1'b1;
                    pend_idx_d = up_idx;
                    pend_val_d = sat_update(upd_base, upd_taken);
                end
            end
            default: begin
                state_d     = BHT_INIT;
                sweep_idx_d = '0;
            end
        endcase

        // A clear overrides whatever this cycle was doing, including an update
        // arriving in the same cycle; the sweep rewrites every entry anyway.
        if (clear_req) begin
            state_d     = BHT_INIT;
            sweep_idx_d = '0;
            pend_v_d    = 1'b0;
            ram_we      = 1'b0;
            accept      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BHT_INIT;
            sweep_idx_q <= '0;
            pend_v_q    <= 1'b0;
            pend_idx_q  <= '0;
            pend_val_q  <= INIT_CTR;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
            pend_v_q    <= pend_v_d;
            pend_idx_q  <= pend_idx_d;
            pend_val_q  <= pend_val_d;
        end
    end

    // Statistics: [0] counts accepted branches, [1] accepted mispredicts.
    logic [1:0] cnt_inc;
    assign cnt_inc[0] = accept;
    assign cnt_inc[1] = accept && upd_mispredict;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [31:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (clear_req) begin
                    cnt_d = '0;
                end else if (cnt_inc[gi] && (cnt_q != 32'hFFFF_FFFF)) begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    assign branch_cnt     = g_cnt[0].cnt_q;
    assign mispredict_cnt = g_cnt[1].cnt_q;

endmodule

// File: tb/tb_bht_controller.sv
// Self-checking bench for bht_controller. The reference model keeps an integer
// counter per table entry that changes the moment an update is accepted, plus a
// countdown of remaining busy cycles; predictions are read from it directly.
module tb_bht_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear_req;
    logic [31:0] lookup_pc;
    logic        predict_taken;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        upd_mispredict;
    logic        busy;
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;

    always #5 clk = ~clk;

    bht_controller #(
        .IDX_W    (10),
        .INIT_CTR (2'b01)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .clear_req      (clear_req),
        .lookup_pc      (lookup_pc),
        .predict_taken  (predict_taken),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_mispredict (upd_mispredict),
        .busy           (busy),
        .branch_cnt     (branch_cnt),
        .mispredict_cnt (mispredict_cnt)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    int      ctr_m [1024];
    int      busy_m;
    longint  bc_m, mc_m;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'(pc[11:2]);
    endfunction

    task automatic drive(input logic [31:0] lk, input logic uv, input logic [31:0] upc,
                         input logic ut, input logic um, input logic clr);
        lookup_pc      = lk;
        upd_valid      = uv;
        upd_pc         = upc;
        upd_taken      = ut;
        upd_mispredict = um;
        clear_req      = clr;
    endtask

    // One clock cycle: optionally compare all outputs against the model, then
    // advance the model with the inputs present at the rising edge.
    task automatic cycle(input bit do_chk);
        int  i;
        logic exp_pred;
        #1;
        if (do_chk) begin
            exp_pred = (busy_m == 0) && (ctr_m[idx_of(lookup_pc)] >= 2);
            chk("busy", {31'd0, busy}, {31'd0, busy_m > 0});
            chk("predict", {31'd0, predict_taken}, {31'd0, exp_pred});
            chk("branch_cnt", branch_cnt, bc_m[31:0]);
            chk("mispredict_cnt", mispredict_cnt, mc_m[31:0]);
        end
        @(posedge clk);
        if (rst || clear_req) begin
            busy_m = 1024;
            for (int k = 0; k < 1024; k++) ctr_m[k] = 1;
            bc_m = 0;
            mc_m = 0;
        end else begin
            if (upd_valid && busy_m == 0) begin
                i = idx_of(upd_pc);
                if (upd_taken) ctr_m[i] = (ctr_m[i] == 3) ? 3 : ctr_m[i] + 1;
                else           ctr_m[i] = (ctr_m[i] == 0) ? 0 : ctr_m[i] - 1;
                if (bc_m != 64'hFFFF_FFFF) bc_m++;
                if (upd_mispredict && mc_m != 64'hFFFF_FFFF) mc_m++;
                $display("[TB] upd idx=%0d taken=%0b misp=%0b -> ctr=%0d", i, upd_taken,
                         upd_mispredict, ctr_m[i]);
            end
            if (busy_m > 0) busy_m--;
        end
        @(negedge clk);
    endtask

    // Idle RUN/INIT cycles with a random lookup and no update.
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            drive($urandom, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            cycle(1);
        end
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken, input logic misp);
        drive(pc, 1'b1, pc, taken, misp, 1'b0);
        cycle(1);
    endtask

    // Lookup pc and compare predict_taken with a hand-derived constant.
    task automatic look(input string tag, input logic [31:0] pc, input logic exp);
        drive(pc, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk(tag, {31'd0, predict_taken}, {31'd0, exp});
        cycle(1);
    endtask

    initial begin
        busy_m = 0;
        bc_m   = 0;
        mc_m   = 0;
        for (int k = 0; k < 1024; k++) ctr_m[k] = 1;
        drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        cycle(0);
        cycle(0);
        rst = 1'b0;

        // Reset release: explicit reset-state values, then 1024 busy cycles
        // with random updates that must all be dropped.
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_pred", {31'd0, predict_taken}, 32'd0);
        chk("rst_bcnt", branch_cnt, 32'd0);
        chk("rst_mcnt", mispredict_cnt, 32'd0);
        for (int k = 0; k < 1024; k++) begin
            drive($urandom, 1'($urandom), $urandom, 1'($urandom), 1'($urandom), 1'b0);
            if (k == 1023) begin
                #1;
                chk("busy_last", {31'd0, busy}, 32'd1);
            end
            cycle(1);
        end
        #1;
        chk("busy_fall", {31'd0, busy}, 32'd0);
        chk("init_drop_bcnt", branch_cnt, 32'd0);

        // Every index reads weakly-not-taken.
        for (int k = 0; k < 1024; k++) begin
            drive(32'(k) << 2, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            cycle(1);
        end

        // Saturation at 0x40, plus aliasing 0x1040 -> same entry.
        upd(32'h40, 1'b1, 1'b0);
        upd(32'h40, 1'b1, 1'b0);
        upd(32'h40, 1'b1, 1'b0);
        look("sat_hi", 32'h40, 1'b1);
        look("alias", 32'h1040, 1'b1);
        for (int k = 0; k < 4; k++) upd(32'h40, 1'b0, 1'b0);
        look("sat_lo", 32'h40, 1'b0);
        upd(32'h40, 1'b1, 1'b0);
        look("sat_lo_floor", 32'h40, 1'b0);   // 00 -> 01, not 10

        // Forwarding at 0x80.
        drive(32'h80, 1'b1, 32'h80, 1'b1, 1'b0, 1'b0);
        #1;
        chk("fwd_N", {31'd0, predict_taken}, 32'd0);
        cycle(1);
        look("fwd_N1", 32'h80, 1'b1);

        // Back-to-back on 0x100: 01 -> 10 -> 11, one not-taken keeps it at 10.
        upd(32'h100, 1'b1, 1'b0);
        upd(32'h100, 1'b1, 1'b0);
        upd(32'h100, 1'b0, 1'b0);
        look("b2b_tt", 32'h100, 1'b1);
        // Not-taken then taken on fresh 0x140: 01 -> 00 -> 01.
        upd(32'h140, 1'b0, 1'b0);
        upd(32'h140, 1'b1, 1'b0);
        look("b2b_nt", 32'h140, 1'b0);

        // Clear mid-operation with a same-cycle update.
        for (int k = 0; k < 3; k++) upd(32'h40, 1'b1, 1'b1);
        look("pre_clr", 32'h40, 1'b1);
        drive(32'h40, 1'b1, 32'h40, 1'b1, 1'b1, 1'b1);
        cycle(1);
        #1;
        chk("clr_bcnt", branch_cnt, 32'd0);
        chk("clr_busy", {31'd0, busy}, 32'd1);
        idle(1024);
        look("clr_lookup", 32'h40, 1'b0);

        // Statistics: 5 updates, 2 mispredicts.
        upd(32'h200, 1'b1, 1'b1);
        upd(32'h204, 1'b0, 1'b0);
        upd(32'h208, 1'b1, 1'b0);
        upd(32'h200, 1'b0, 1'b1);
        upd(32'h20c, 1'b1, 1'b0);
        #1;
        chk("stat_bcnt", branch_cnt, 32'd5);
        chk("stat_mcnt", mispredict_cnt, 32'd2);
        // Clear, then updates during INIT change nothing.
        drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        cycle(1);
        for (int k = 0; k < 20; k++) upd(32'h200, 1'b1, 1'b1);
        #1;
        chk("init_bcnt", branch_cnt, 32'd0);
        chk("init_mcnt", mispredict_cnt, 32'd0);
        idle(1004);

        // Random traffic over a small index set to exercise forwarding hazards.
        for (int k = 0; k < 4000; k++) begin
            logic [31:0] lpc, upc;
            lpc = (32'($urandom_range(0, 7)) << 2) | (($urandom_range(0, 3) == 0) ? 32'h1000 : 32'h0);
            upc = (32'($urandom_range(0, 7)) << 2) | (($urandom_range(0, 3) == 0) ? 32'h1000 : 32'h0);
            drive(lpc, ($urandom_range(0, 2) != 0), upc, 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 1499) == 0));
            cycle(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
